rob_multiport: RTL and testbench

// - Parametrised reorder buffer for the out-of-order-completion pipeline; successor to the fixed 3-port, 16-slot ROB.
// - Sits between decode (in-order allocation) and the register file (in-order commit).
// - Accepts N_WB independent write-back ports (ALU, MULT, DCache, ...).
// - Commits one entry per cycle; raises precise exceptions at commit and self-flushes.

---
 rtl/rob_multiport_pkg.sv | 17 +
 rtl/rob_multiport_if.sv | 59 +++++
 rtl/rob_wb_select.sv | 60 ++++++
 rtl/rob_multiport.sv | 172 +++++++++++++++++
 tb/tb_rob_multiport.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rob_multiport_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rob_multiport_pkg
//  Description : Shared processor-wide widths for the reorder buffer and its
//                neighbours (data/pc width, register index, ROB slot index,
//                number of write-back ports).
//  Revision    : 1.0 - initial parametrised multi-port release
// ============================================================================
package rob_multiport_pkg;

    localparam int C_ARCH_BITS    = 32;
    localparam int C_REG_IDX_BITS = 5;
    localparam int C_ROB_IDX_BITS = 4;
    localparam int C_N_WB         = 3;

endpackage : rob_multiport_pkg
`default_nettype wire

// File: rtl/rob_multiport_if.sv
`default_nettype none
// ============================================================================
//  Module      : rob_multiport_if
//  Description : Bus between decode / write-back units / register file and
//                the reorder buffer.
//                  flush, alloc_*         : decode side (alloc_idx = granted slot)
//                  wb_*                   : N_WB packed write-back ports
//                  commit_*, except_*     : in-order retire side
//                  count                  : occupied slots
//                slave  = ROB side, master = pipeline side.
//  Revision    : 1.0 - initial parametrised multi-port release
// ============================================================================
interface rob_multiport_if
    import rob_multiport_pkg::*;
#(
    parameter int ARCH_BITS    = C_ARCH_BITS,
    parameter int REG_IDX_BITS = C_REG_IDX_BITS,
    parameter int ROB_IDX_BITS = C_ROB_IDX_BITS,
    parameter int N_WB         = C_N_WB
);
    logic                           flush;
    logic                           alloc_valid;
    logic                           alloc_ready;
    logic [ROB_IDX_BITS-1:0]        alloc_idx;
    logic [N_WB-1:0]                wb_valid;
    logic [N_WB*ROB_IDX_BITS-1:0]   wb_idx;
    logic [N_WB-1:0]                wb_except;
    logic [N_WB*ARCH_BITS-1:0]      wb_pc;
    logic [N_WB*ARCH_BITS-1:0]      wb_addr;
    logic [N_WB*ARCH_BITS-1:0]      wb_data;
    logic [N_WB*REG_IDX_BITS-1:0]   wb_dst;
    logic [N_WB-1:0]                wb_we;
    logic                           commit_valid;
    logic [REG_IDX_BITS-1:0]        commit_dst;
    logic [ARCH_BITS-1:0]           commit_data;
    logic                           commit_we;
    logic                           except_valid;
    logic [ARCH_BITS-1:0]           except_addr;
    logic [ARCH_BITS-1:0]           except_pc;
    logic [ROB_IDX_BITS:0]          count;

    modport slave (
        input  flush, alloc_valid,
        input  wb_valid, wb_idx, wb_except, wb_pc, wb_addr, wb_data, wb_dst, wb_we,
        output alloc_ready, alloc_idx,
        output commit_valid, commit_dst, commit_data, commit_we,
        output except_valid, except_addr, except_pc, count
    );

    modport master (
        output flush, alloc_valid,
        output wb_valid, wb_idx, wb_except, wb_pc, wb_addr, wb_data, wb_dst, wb_we,
        input  alloc_ready, alloc_idx,
        input  commit_valid, commit_dst, commit_data, commit_we,
        input  except_valid, except_addr, except_pc, count
    );

endinterface : rob_multiport_if
`default_nettype wire

// File: rtl/rob_wb_select.sv
`default_nettype none
// ============================================================================
//  Module      : rob_wb_select
//  Description : Priority select of the write-back ports for one ROB slot.
//                Ports: wb_* (packed N_WB port bundle) in;
//                       hit + winning payload (sel_*) out.
//                Port 0 has the highest priority.
//  Revision    : 1.0 - initial parametrised multi-port release
// ============================================================================
module rob_wb_select
    import rob_multiport_pkg::*;
#(
    parameter int ARCH_BITS    = C_ARCH_BITS,
    parameter int REG_IDX_BITS = C_REG_IDX_BITS,
    parameter int ROB_IDX_BITS = C_ROB_IDX_BITS,
    parameter int N_WB         = C_N_WB,
    parameter int SLOT         = 0
) (
    input  wire logic [N_WB-1:0]              wb_valid,
    input  wire logic [N_WB*ROB_IDX_BITS-1:0] wb_idx,
    input  wire logic [N_WB-1:0]              wb_except,
    input  wire logic [N_WB*ARCH_BITS-1:0]    wb_pc,
    input  wire logic [N_WB*ARCH_BITS-1:0]    wb_addr,
    input  wire logic [N_WB*ARCH_BITS-1:0]    wb_data,
    input  wire logic [N_WB*REG_IDX_BITS-1:0] wb_dst,
    input  wire logic [N_WB-1:0]              wb_we,
    output logic                              hit,
    output logic                              sel_except,
    output logic [ARCH_BITS-1:0]              sel_pc,
    output logic [ARCH_BITS-1:0]              sel_addr,
    output logic [ARCH_BITS-1:0]              sel_data,
    output logic [REG_IDX_BITS-1:0]           sel_dst,
    output logic                              sel_we
);

    // Scan from the highest port down so the lowest matching port is the
    // last assignment and therefore wins.
    always_comb begin
        hit        = 1'b0;
        sel_except = 1'b0;
        sel_pc     = '0;
        sel_addr   = '0;
        sel_data   = '0;
        sel_dst    = '0;
        sel_we     = 1'b0;
        for (int p = N_WB - 1; p >= 0; p--) begin
            if (wb_valid[p] && (wb_idx[p*ROB_IDX_BITS +: ROB_IDX_BITS] == ROB_IDX_BITS'(SLOT))) begin
                hit        = 1'b1;
                sel_except = wb_except[p];
                sel_pc     = wb_pc[p*ARCH_BITS +: ARCH_BITS];
                sel_addr   = wb_addr[p*ARCH_BITS +: ARCH_BITS];
                sel_data   = wb_data[p*ARCH_BITS +: ARCH_BITS];
                sel_dst    = wb_dst[p*REG_IDX_BITS +: REG_IDX_BITS];
                sel_we     = wb_we[p];
            end
        end
    end

endmodule : rob_wb_select
`default_nettype wire

// File: rtl/rob_multiport.sv
`default_nettype none
// ============================================================================
//  Module      : rob_multiport
//  Description : Parametrised reorder buffer. In-order allocation from decode,
//                out-of-order completion on N_WB write-back ports, in-order
//                commit of one entry per cycle with precise exceptions.
//                Ports: clk, rst (sync, active-high), bus (rob_multiport_if
//                slave: flush/alloc/wb in, alloc_ready/idx, commit, except,
//                count out).
//  Revision    : 1.0 - initial parametrised multi-port release
// ============================================================================
module rob_multiport
    import rob_multiport_pkg::*;
#(
    parameter int ARCH_BITS    = C_ARCH_BITS,
    parameter int REG_IDX_BITS = C_REG_IDX_BITS,
    parameter int ROB_IDX_BITS = C_ROB_IDX_BITS,
    parameter int N_WB         = C_N_WB
) (
    input  wire logic     clk,
    input  wire logic     rst,
    rob_multiport_if.slave bus
);

    localparam int ROB_SLOTS = 2 ** ROB_IDX_BITS;
    localparam int PTR_BITS  = ROB_IDX_BITS + 1;

    // Pointers carry a wrap bit in the MSB to tell full from empty.
    logic [PTR_BITS-1:0]     head_q, head_d, tail_q, tail_d;
    logic [ROB_SLOTS-1:0]    alloc_q, alloc_d, done_q, done_d;

    // Payload (not reset; only meaningful while alloc/done are set).
    logic [ROB_SLOTS-1:0]    except_q, except_d, we_q, we_d;
    logic [ARCH_BITS-1:0]    pc_q   [ROB_SLOTS];
    logic [ARCH_BITS-1:0]    pc_d   [ROB_SLOTS];
    logic [ARCH_BITS-1:0]    addr_q [ROB_SLOTS];
    logic [ARCH_BITS-1:0]    addr_d [ROB_SLOTS];
    logic [ARCH_BITS-1:0]    data_q [ROB_SLOTS];
    logic [ARCH_BITS-1:0]    data_d [ROB_SLOTS];
    logic [REG_IDX_BITS-1:0] dst_q  [ROB_SLOTS];
    logic [REG_IDX_BITS-1:0] dst_d  [ROB_SLOTS];

    // Per-slot write-back select results.
    logic [ROB_SLOTS-1:0]    sel_hit, sel_except, sel_we;
    logic [ARCH_BITS-1:0]    sel_pc   [ROB_SLOTS];
    logic [ARCH_BITS-1:0]    sel_addr [ROB_SLOTS];
    logic [ARCH_BITS-1:0]    sel_data [ROB_SLOTS];
    logic [REG_IDX_BITS-1:0] sel_dst  [ROB_SLOTS];

    generate
        for (genvar s = 0; s < ROB_SLOTS; s++) begin : g_slot
            rob_wb_select #(
                .ARCH_BITS    (ARCH_BITS),
                .REG_IDX_BITS (REG_IDX_BITS),
                .ROB_IDX_BITS (ROB_IDX_BITS),
                .N_WB         (N_WB),
                .SLOT         (s)
            ) u_sel (
                .wb_valid   (bus.wb_valid),
                .wb_idx     (bus.wb_idx),
                .wb_except  (bus.wb_except),
                .wb_pc      (bus.wb_pc),
                .wb_addr    (bus.wb_addr),
                .wb_data    (bus.wb_data),
                .wb_dst     (bus.wb_dst),
                .wb_we      (bus.wb_we),
                .hit        (sel_hit[s]),
                .sel_except (sel_except[s]),
                .sel_pc     (sel_pc[s]),
                .sel_addr   (sel_addr[s]),
                .sel_data   (sel_data[s]),
                .sel_dst    (sel_dst[s]),
                .sel_we     (sel_we[s])
            );
        end
    endgenerate

    logic [ROB_IDX_BITS-1:0] head_idx, tail_idx;
    logic                    full, head_ready, commit_fire, except_fire, alloc_fire;

    assign head_idx    = head_q[ROB_IDX_BITS-1:0];
    assign tail_idx    = tail_q[ROB_IDX_BITS-1:0];
    assign full        = (head_idx == tail_idx) && (head_q[ROB_IDX_BITS] != tail_q[ROB_IDX_BITS]);
    assign head_ready  = alloc_q[head_idx] & done_q[head_idx];
    assign commit_fire = head_ready & ~except_q[head_idx];
    assign except_fire = head_ready &  except_q[head_idx];
    // An exception at head discards any same-cycle allocation.
    assign alloc_fire  = bus.alloc_valid & ~full & ~except_fire;

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        alloc_d  = alloc_q;
        done_d   = done_q;
        except_d = except_q;
        we_d     = we_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        data_d   = data_q;
        dst_d    = dst_q;

        for (int s = 0; s < ROB_SLOTS; s++) begin
            if (sel_hit[s] && alloc_q[s]) begin
                done_d[s]   = 1'b1;
                except_d[s] = sel_except[s];
                we_d[s]     = sel_we[s];
                pc_d[s]     = sel_pc[s];
                addr_d[s]   = sel_addr[s];
                data_d[s]   = sel_data[s];
                dst_d[s]    = sel_dst[s];
            end
        end

        // Commit is applied after write-back so a late write to the head
        // slot cannot resurrect it.
        if (commit_fire) begin
            alloc_d[head_idx] = 1'b0;
            done_d[head_idx]  = 1'b0;
            head_d            = head_q + PTR_BITS'(1);
        end

        if (alloc_fire) begin
            alloc_d[tail_idx] = 1'b1;
            done_d[tail_idx]  = 1'b0;
            tail_d            = tail_q + PTR_BITS'(1);
        end

        // Precise exception: drop everything younger than (and including) head.
        if (except_fire) begin
            tail_d  = head_q;
            alloc_d = '0;
            done_d  = '0;
        end

        if (rst || bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            alloc_d = '0;
            done_d  = '0;
        end
    end

    // Control state: reset is folded into the _d logic above.
    always_ff @(posedge clk) begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        alloc_q <= alloc_d;
        done_q  <= done_d;
    end

    always_ff @(posedge clk) begin
        except_q <= except_d;
        we_q     <= we_d;
        pc_q     <= pc_d;
        addr_q   <= addr_d;
        data_q   <= data_d;
        dst_q    <= dst_d;
    end

    assign bus.alloc_ready  = ~full;
    assign bus.alloc_idx    = tail_idx;
    assign bus.count        = tail_q - head_q;
    assign bus.commit_valid = commit_fire;
    assign bus.commit_dst   = commit_fire ? dst_q[head_idx]  : '0;
    assign bus.commit_data  = commit_fire ? data_q[head_idx] : '0;
    assign bus.commit_we    = commit_fire & we_q[head_idx];
    assign bus.except_valid = except_fire;
    assign bus.except_addr  = except_fire ? addr_q[head_idx] : '0;
    assign bus.except_pc    = except_fire ? pc_q[head_idx]   : '0;

endmodule : rob_multiport
`default_nettype wire

// File: tb/tb_rob_multiport.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rob_multiport
//  Description : Directed self-checking bench for rob_multiport.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_multiport;
    import rob_multiport_pkg::*;

    localparam int AB    = C_ARCH_BITS;
    localparam int RB    = C_REG_IDX_BITS;
    localparam int IB    = C_ROB_IDX_BITS;
    localparam int NW    = C_N_WB;
    localparam int SLOTS = 2 ** IB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    rob_multiport_if #(.ARCH_BITS(AB), .REG_IDX_BITS(RB), .ROB_IDX_BITS(IB), .N_WB(NW)) bus ();

    rob_multiport #(.ARCH_BITS(AB), .REG_IDX_BITS(RB), .ROB_IDX_BITS(IB), .N_WB(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.flush       = 1'b0;
        bus.alloc_valid = 1'b0;
        bus.wb_valid    = '0;
        bus.wb_idx      = '0;
        bus.wb_except   = '0;
        bus.wb_pc       = '0;
        bus.wb_addr     = '0;
        bus.wb_data     = '0;
        bus.wb_dst      = '0;
        bus.wb_we       = '0;
    endtask

    task automatic wb_set(input int p, input int idx, input logic [AB-1:0] data,
                          input logic [RB-1:0] dst, input logic exc,
                          input logic [AB-1:0] pc, input logic [AB-1:0] addr);
        bus.wb_valid[p]           = 1'b1;
        bus.wb_idx[p*IB +: IB]    = IB'(idx);
        bus.wb_except[p]          = exc;
        bus.wb_pc[p*AB +: AB]     = pc;
        bus.wb_addr[p*AB +: AB]   = addr;
        bus.wb_data[p*AB +: AB]   = data;
        bus.wb_dst[p*RB +: RB]    = dst;
        bus.wb_we[p]              = 1'b1;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic alloc_n(input int n);
        bus.alloc_valid = 1'b1;
        repeat (n) step();
        bus.alloc_valid = 1'b0;
    endtask

    // Bounded search for the commit of a given destination register.
    task automatic wait_commit(input string tag, input logic [RB-1:0] dst, input logic [AB-1:0] exp);
        logic            found = 1'b0;
        logic [AB-1:0]   got   = '0;
        for (int i = 0; i < 20; i++) begin
            if (bus.commit_valid && bus.commit_dst == dst) begin
                found = 1'b1;
                got   = bus.commit_data;
                break;
            end
            step();
        end
        check({tag, "_seen"}, found, 1);
        check(tag, got, exp);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        saw;
        int          model_cnt, seq, rounds, commits, wbk;
        bit          filling, commit_now, do_alloc;
        logic [AB-1:0] expq[$];
        int          pidx[$];
        logic [AB-1:0] pdata[$];

        // ---------------- reset state ----------------
        do_reset();
        check("rst_alloc_ready", bus.alloc_ready, 1);
        check("rst_alloc_idx", bus.alloc_idx, 0);
        check("rst_count", bus.count, 0);
        check("rst_commit_valid", bus.commit_valid, 0);
        check("rst_except_valid", bus.except_valid, 0);

        // ---------------- fill to full ----------------
        for (int i = 0; i < SLOTS; i++) begin
            check("fill_alloc_idx", bus.alloc_idx, i);
            bus.alloc_valid = 1'b1;
            step();
        end
        check("full_alloc_ready", bus.alloc_ready, 0);
        check("full_count", bus.count, SLOTS);
        step();  // 17th request while full
        check("full_ignored_count", bus.count, SLOTS);
        check("full_ignored_idx", bus.alloc_idx, 0);
        check("full_no_commit", bus.commit_valid, 0);
        bus.alloc_valid = 1'b0;

        // ---------------- out-of-order completion ----------------
        do_reset();
        alloc_n(3);
        clear_in();
        wb_set(2, 2, 32'h33, 5'd3, 1'b0, 32'h0, 32'h0);
        step();
        clear_in();
        check("ooo_wait0", bus.commit_valid, 0);
        wb_set(1, 1, 32'h22, 5'd2, 1'b0, 32'h0, 32'h0);
        step();
        clear_in();
        check("ooo_wait1", bus.commit_valid, 0);
        wb_set(0, 0, 32'h11, 5'd1, 1'b0, 32'h0, 32'h0);
        step();
        clear_in();
        check("ooo_c0_valid", bus.commit_valid, 1);
        check("ooo_c0_data", bus.commit_data, 32'h11);
        check("ooo_c0_dst", bus.commit_dst, 1);
        check("ooo_c0_we", bus.commit_we, 1);
        step();
        check("ooo_c1_valid", bus.commit_valid, 1);
        check("ooo_c1_data", bus.commit_data, 32'h22);
        step();
        check("ooo_c2_valid", bus.commit_valid, 1);
        check("ooo_c2_data", bus.commit_data, 32'h33);
        step();
        check("ooo_done_valid", bus.commit_valid, 0);
        check("ooo_done_count", bus.count, 0);

        // ---------------- port collision ----------------
        do_reset();
        alloc_n(6);
        clear_in();
        wb_set(0, 5, 32'hAAAA, 5'd5, 1'b0, 32'h0, 32'h0);
        wb_set(1, 5, 32'hBBBB, 5'd6, 1'b0, 32'h0, 32'h0);
        step();
        for (int i = 0; i < 5; i++) begin
            clear_in();
            wb_set(0, i, AB'(i), RB'(i), 1'b0, 32'h0, 32'h0);
            step();
        end
        clear_in();
        wait_commit("collide_data", 5'd5, 32'hAAAA);

        // ---------------- exception ----------------
        do_reset();
        alloc_n(4);
        clear_in();
        wb_set(0, 0, 32'h10, 5'd1, 1'b0, 32'h0, 32'h0);
        wb_set(1, 1, 32'hDEAD, 5'd2, 1'b1, 32'h1004, 32'h8000);
        wb_set(2, 2, 32'h30, 5'd3, 1'b0, 32'h0, 32'h0);
        step();
        clear_in();
        wb_set(0, 3, 32'h40, 5'd4, 1'b0, 32'h0, 32'h0);
        check("exc_c0_valid", bus.commit_valid, 1);
        check("exc_c0_data", bus.commit_data, 32'h10);
        check("exc_c0_no_exc", bus.except_valid, 0);
        step();
        clear_in();
        check("exc_valid", bus.except_valid, 1);
        check("exc_pc", bus.except_pc, 32'h1004);
        check("exc_addr", bus.except_addr, 32'h8000);
        check("exc_commit_blocked", bus.commit_valid, 0);
        bus.alloc_valid = 1'b1;  // dropped by the exception
        step();
        bus.alloc_valid = 1'b0;
        check("exc_count", bus.count, 0);
        check("exc_pulse_end", bus.except_valid, 0);
        check("exc_tail_at_head", bus.alloc_idx, 1);
        saw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            saw = saw | bus.commit_valid;
            step();
        end
        check("exc_no_younger_commit", saw, 0);

        // ---------------- wrap-around ----------------
        do_reset();
        model_cnt = 0; seq = 0; rounds = 0; commits = 0; wbk = 0; filling = 1'b1;
        for (int cyc = 0; cyc < 400 && rounds < 3; cyc++) begin
            clear_in();
            check("wrap_count", bus.count, model_cnt);
            check("wrap_ready", bus.alloc_ready, (model_cnt < SLOTS) ? 1 : 0);
            commit_now = bus.commit_valid;
            do_alloc   = 1'b0;
            if (commit_now) begin
                if (expq.size() > 0) begin
                    check("wrap_commit_data", bus.commit_data, expq.pop_front());
                end else begin
                    check("wrap_unexpected_commit", 1, 0);
                end
                commits++;
            end
            if (filling) begin
                if (model_cnt < SLOTS) begin
                    check("wrap_alloc_idx", bus.alloc_idx, seq % SLOTS);
                    bus.alloc_valid = 1'b1;
                    do_alloc = 1'b1;
                    expq.push_back(AB'(32'h1000 + seq));
                    pidx.push_back(seq % SLOTS);
                    pdata.push_back(AB'(32'h1000 + seq));
                    seq++;
                end else begin
                    filling = 1'b0;
                end
            end else if (pidx.size() > 0) begin
                // Complete youngest first so the whole batch retires in order at the end.
                wb_set(wbk % NW, pidx.pop_back(), pdata.pop_back(), RB'(wbk), 1'b0, 32'h0, 32'h0);
                wbk++;
            end else if (model_cnt == 0) begin
                rounds++;
                filling = 1'b1;
            end
            step();
            model_cnt = model_cnt + (do_alloc ? 1 : 0) - (commit_now ? 1 : 0);
        end
        clear_in();
        check("wrap_rounds", rounds, 3);
        check("wrap_commits", commits, 3 * SLOTS);

        // ---------------- flush mid-operation ----------------
        do_reset();
        alloc_n(2);
        clear_in();
        wb_set(0, 0, 32'h55, 5'd1, 1'b0, 32'h0, 32'h0);
        step();
        clear_in();
        check("flush_pre_commit", bus.commit_valid, 1);
        bus.flush       = 1'b1;
        bus.alloc_valid = 1'b1;
        wb_set(1, 1, 32'h66, 5'd2, 1'b0, 32'h0, 32'h0);
        step();
        clear_in();
        check("flush_count", bus.count, 0);
        check("flush_alloc_idx", bus.alloc_idx, 0);
        check("flush_alloc_ready", bus.alloc_ready, 1);
        check("flush_no_commit", bus.commit_valid, 0);
        step();
        check("flush_still_idle", bus.commit_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rob_multiport
`default_nettype wire
